// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared state encoding and limits for the pipeline controller
package arm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } ctrl_state_e;

  localparam int MIN_MEM_WAIT = 2;
  localparam int MAX_MEM_WAIT = 255;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for performance statistics
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - freeze/flush/bubble sequencing for the 5-stage pipeline
module pipeline_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  output logic             freeze_if,
  output logic             freeze_all,
  output logic             flush,
  output logic             bubble_id,
  output logic             sram_start,
  output logic             mem_ready,
  output logic [CNT_W-1:0] stall_count
);

  if ((MEM_WAIT_CYCLES < MIN_MEM_WAIT) || (MEM_WAIT_CYCLES > MAX_MEM_WAIT)) begin : g_bad_wait
    $error("pipeline_ctrl: MEM_WAIT_CYCLES out of range");
  end

  ctrl_state_e state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        mem_req;
  logic        hazard_ok;

  assign mem_req = mem_r_en | mem_w_en;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    freeze_all = 1'b0;
    sram_start = 1'b0;
    mem_ready  = 1'b0;
    hazard_ok  = 1'b0;
    freeze_if  = 1'b0;
    bubble_id  = 1'b0;
    flush      = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          sram_start = 1'b1;
          freeze_all = 1'b1;
          wait_d     = 8'(MEM_WAIT_CYCLES - 1);
          state_d    = MEM_ACCESS;
        end
      end
      MEM_ACCESS: begin
        freeze_all = 1'b1;
        if (wait_q == 8'd1) begin
          state_d = MEM_DONE;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      MEM_DONE: begin
        mem_ready = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset silences every control in the same cycle, including mid-access.
    if (rst) begin
      state_d    = IDLE;
      wait_d     = 8'd0;
      freeze_all = 1'b0;
      sram_start = 1'b0;
      mem_ready  = 1'b0;
    end else begin
      hazard_ok = hazard_detected & ~branch_taken & ~freeze_all;
      bubble_id = hazard_ok;
      freeze_if = freeze_all | hazard_ok;
      flush     = branch_taken & ~freeze_all;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (freeze_if),
    .count(stall_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int N = 4;

  typedef struct {
    logic       rst;
    logic       haz;
    logic       br;
    logic       mr;
    logic       mw;
    logic [5:0] exp_ctl;
    int         exp_stall;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hazard_detected, branch_taken, mem_r_en, mem_w_en;
  logic        freeze_if, freeze_all, flush, bubble_id, sram_start, mem_ready;
  logic [15:0] stall_count;
  logic        s_fif, s_fall, s_fl, s_bub, s_ss, s_rdy;
  logic [2:0]  s_stall;

  pipeline_ctrl #(.MEM_WAIT_CYCLES(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .freeze_if(freeze_if), .freeze_all(freeze_all),
    .flush(flush), .bubble_id(bubble_id), .sram_start(sram_start), .mem_ready(mem_ready),
    .stall_count(stall_count)
  );

  pipeline_ctrl #(.MEM_WAIT_CYCLES(N), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .freeze_if(s_fif), .freeze_all(s_fall),
    .flush(s_fl), .bubble_id(s_bub), .sram_start(s_ss), .mem_ready(s_rdy),
    .stall_count(s_stall)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_pos;
  longint      m_cnt;
  logic [5:0]  a_ctl;
  logic [15:0] a_stall;
  logic [2:0]  a_sat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // m_pos: 0 = no access, k = k-th frozen cycle of an access, N+1 = data-ready cycle.
  task automatic cycle(input logic r, input logic h, input logic b, input logic mr,
                       input logic mw, input bit en);
    logic       fall, ss, rdy, hz, fl;
    logic [5:0] e;
    longint     sat16, sat3;
    rst = r; hazard_detected = h; branch_taken = b; mem_r_en = mr; mem_w_en = mw;
    @(negedge clk);
    a_ctl   = {freeze_if, freeze_all, flush, bubble_id, sram_start, mem_ready};
    a_stall = stall_count;
    a_sat   = s_stall;
    fall = 1'b0; ss = 1'b0; rdy = 1'b0;
    if (!r) begin
      if (m_pos == 0) begin
        if (mr | mw) begin fall = 1'b1; ss = 1'b1; end
      end else if (m_pos <= N) begin
        fall = 1'b1;
      end else begin
        rdy = 1'b1;
      end
    end
    hz = !r && h && !b && !fall;
    fl = !r && b && !fall;
    e  = {fall | hz, fall, fl, hz, ss, rdy};
    sat16 = (m_cnt > 65535) ? 65535 : m_cnt;
    sat3  = (m_cnt > 7) ? 7 : m_cnt;
    if (en) begin
      chk("model_ctl", 32'(a_ctl), 32'(e));
      chk("model_ctl_w3", 32'({s_fif, s_fall, s_fl, s_bub, s_ss, s_rdy}), 32'(e));
      chk("model_stall", 32'(a_stall), 32'(sat16));
      chk("model_stall_w3", 32'(a_sat), 32'(sat3));
    end
    if (r) begin
      m_pos = 0;
      m_cnt = 0;
    end else begin
      if (fall | hz) m_cnt++;
      if (m_pos == 0)       m_pos = (mr | mw) ? 2 : 0;
      else if (m_pos <= N)  m_pos = m_pos + 1;
      else                  m_pos = 0;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[17];
  int   ss_at[$];
  int   rdy_at[$];
  int   base;

  initial begin
    // ctl = {freeze_if, freeze_all, flush, bubble_id, sram_start, mem_ready}
    tbl[0]  = '{0, 0, 0, 1, 0, 6'b110010, 0};
    tbl[1]  = '{0, 0, 0, 1, 0, 6'b110000, 1};
    tbl[2]  = '{0, 0, 0, 1, 0, 6'b110000, 2};
    tbl[3]  = '{0, 0, 0, 1, 0, 6'b110000, 3};
    tbl[4]  = '{0, 0, 0, 1, 0, 6'b000001, 4};
    tbl[5]  = '{0, 0, 0, 0, 0, 6'b000000, 4};
    tbl[6]  = '{0, 1, 0, 0, 0, 6'b100100, 4};
    tbl[7]  = '{0, 1, 0, 0, 0, 6'b100100, 5};
    tbl[8]  = '{0, 0, 0, 0, 0, 6'b000000, 6};
    tbl[9]  = '{0, 1, 1, 0, 0, 6'b001000, 6};
    tbl[10] = '{0, 0, 0, 0, 0, 6'b000000, 6};
    tbl[11] = '{0, 0, 0, 0, 1, 6'b110010, 6};
    tbl[12] = '{0, 0, 1, 0, 1, 6'b110000, 7};
    tbl[13] = '{0, 1, 1, 0, 1, 6'b110000, 8};
    tbl[14] = '{0, 0, 1, 0, 1, 6'b110000, 9};
    tbl[15] = '{0, 0, 1, 0, 1, 6'b001001, 10};
    tbl[16] = '{0, 0, 0, 0, 0, 6'b000000, 10};

    m_pos = 0; m_cnt = 0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].haz, tbl[i].br, tbl[i].mr, tbl[i].mw, 1);
      chk($sformatf("tbl_ctl[%0d]", i), 32'(a_ctl), 32'(tbl[i].exp_ctl));
      chk($sformatf("tbl_stall[%0d]", i), 32'(a_stall), 32'(tbl[i].exp_stall));
    end

    // Reset during the second MEM_ACCESS cycle.
    cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);
    cycle(1, 1, 1, 1, 0, 1);
    chk("rst_outputs", 32'(a_ctl), 32'd0);
    cycle(0, 0, 0, 1, 0, 1);
    chk("rst_stall_cleared", 32'(a_stall), 32'd0);
    chk("rst_stall_w3_cleared", 32'(a_sat), 32'd0);
    chk("rst_restart", 32'(a_ctl), 32'(6'b110010));
    repeat (4) cycle(0, 0, 0, 1, 0, 1);
    chk("rst_access_ready", 32'(a_ctl), 32'(6'b000001));
    cycle(0, 0, 0, 0, 0, 1);
    base = int'(a_stall);

    // Back-to-back loads with mem_r_en held across both.
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 1, 0, 1);
      if (a_ctl[1]) ss_at.push_back(i);
      if (a_ctl[0]) rdy_at.push_back(i);
    end
    cycle(0, 0, 0, 0, 0, 1);
    chk("b2b_stall", 32'(a_stall), 32'(base + 8));
    chk("sat_stall_w3", 32'(a_sat), 32'd7);
    chk("b2b_start_count", 32'(ss_at.size()), 32'd2);
    chk("b2b_ready_count", 32'(rdy_at.size()), 32'd2);
    if (ss_at.size() == 2) chk("b2b_start_gap", 32'(ss_at[1] - ss_at[0]), 32'd5);
    if (rdy_at.size() == 2) begin
      chk("b2b_ready_first", 32'(rdy_at[0]), 32'd4);
      chk("b2b_ready_second", 32'(rdy_at[1]), 32'd9);
    end

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
